// File: rtl/growl_seq_ctrl_if.sv
// Sequencer-to-core bundle for growl_seq_ctrl.
// master: control decoder / core side; slave: the sequencer itself.
interface growl_seq_ctrl_if #(
  parameter int unsigned VEC_W = 5,
  parameter int unsigned PC_W  = 16
) ();
  // Core -> sequencer
  logic             hold;
  logic [1:0]       c_next_state;
  logic             c_skip;
  logic             skip_cond;
  logic             next_two_word;
  logic             irq_req;
  logic [VEC_W-1:0] irq_vec;
  logic             sreg_i;
  logic             reti_done;
  logic [PC_W-1:0]  pc_cur;
  // Sequencer -> core
  logic [1:0]       state;
  logic             squash;
  logic             irq_ack;
  logic             irq_busy;
  logic             push_en;
  logic [7:0]       push_data;
  logic             pc_load;
  logic [PC_W-1:0]  pc_target;
  logic             clr_i;

  modport master (
    output hold, c_next_state, c_skip, skip_cond, next_two_word,
           irq_req, irq_vec, sreg_i, reti_done, pc_cur,
    input  state, squash, irq_ack, irq_busy, push_en, push_data,
           pc_load, pc_target, clr_i
  );

  modport slave (
    input  hold, c_next_state, c_skip, skip_cond, next_two_word,
           irq_req, irq_vec, sreg_i, reti_done, pc_cur,
    output state, squash, irq_ack, irq_busy, push_en, push_data,
           pc_load, pc_target, clr_i
  );
endinterface

// File: rtl/growl_seq_ctrl.sv
// Multi-cycle sequencer for the growl core: owns the instruction-phase register,
// squashes skipped words and inserts the 3-cycle interrupt entry sequence.
// Optional macro GROWL_RETI_GUARD_EN: forces one main-program instruction
// between RETI and the next interrupt entry.
module growl_seq_ctrl #(
  parameter int unsigned VEC_W    = 5,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned VEC_BASE = 0
) (
  input  logic            clk,
  input  logic            rst,
  growl_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StRun,
    StSkip1,
    StSkip2,
    StIrqLo,
    StIrqHi,
    StIrqJmp
  } fsm_e;

  fsm_e             r_fsm, w_fsm_nxt;
  logic [1:0]       r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt;
  logic [VEC_W-1:0] r_vec, w_vec_nxt;

  logic             w_boundary;
  logic             w_irq_allowed;
  logic [15:0]      w_pc_ext;
  logic [PC_W-1:0]  w_vec_addr;

  logic             w_squash, w_irq_ack, w_irq_busy, w_push_en, w_pc_load, w_clr_i;
  logic [7:0]       w_push_data;
  logic [PC_W-1:0]  w_pc_target;

  assign w_boundary = (bus.c_next_state == 2'd0);
  // Return PC widened/narrowed to two bytes; bits above PC_W read as zero.
  assign w_pc_ext   = 16'(r_pc);
  assign w_vec_addr = PC_W'(VEC_BASE) + (PC_W'(r_vec) << 1);

`ifdef GROWL_RETI_GUARD_EN
  logic r_guard, w_guard_nxt;

  // A coincident reti_done also blocks entry so the guard is never bypassed.
  assign w_irq_allowed = ~(r_guard | bus.reti_done);

  // Guard sets on RETI completion and clears at the next boundary taken in RUN.
  always_comb begin
    w_guard_nxt = r_guard;
    if (!bus.hold) begin
      if (r_fsm == StRun && w_boundary) w_guard_nxt = 1'b0;
      if (bus.reti_done)                w_guard_nxt = 1'b1;
    end
  end

  // Guard flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_guard <= 1'b0;
    else     r_guard <= w_guard_nxt;
  end
`else
  assign w_irq_allowed = 1'b1;
`endif

  // Next-state and output decode; hold freezes state and suppresses pulses.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_vec_nxt   = r_vec;
    w_squash    = 1'b0;
    w_irq_ack   = 1'b0;
    w_irq_busy  = 1'b0;
    w_push_en   = 1'b0;
    w_push_data = 8'h00;
    w_pc_load   = 1'b0;
    w_pc_target = '0;
    w_clr_i     = 1'b0;

    unique case (r_fsm)
      StRun: begin
        w_state_nxt = bus.c_next_state;
        if (w_boundary) begin
          // Skip wins; a pending interrupt is retried at the post-skip boundary.
          if (bus.c_skip && bus.skip_cond) begin
            w_fsm_nxt = StSkip1;
          end else if (bus.irq_req && bus.sreg_i && w_irq_allowed) begin
            w_fsm_nxt = StIrqLo;
            w_pc_nxt  = bus.pc_cur;
            w_vec_nxt = bus.irq_vec;
            w_irq_ack = 1'b1;
          end
        end
      end
      StSkip1: begin
        w_squash    = 1'b1;
        w_state_nxt = 2'd0;
        w_fsm_nxt   = bus.next_two_word ? StSkip2 : StRun;
      end
      StSkip2: begin
        w_squash    = 1'b1;
        w_state_nxt = 2'd0;
        w_fsm_nxt   = StRun;
      end
      StIrqLo: begin
        w_squash    = 1'b1;
        w_irq_busy  = 1'b1;
        w_push_en   = 1'b1;
        w_push_data = w_pc_ext[7:0];
        w_state_nxt = 2'd0;
        w_fsm_nxt   = StIrqHi;
      end
      StIrqHi: begin
        w_squash    = 1'b1;
        w_irq_busy  = 1'b1;
        w_push_en   = 1'b1;
        w_push_data = w_pc_ext[15:8];
        w_state_nxt = 2'd0;
        w_fsm_nxt   = StIrqJmp;
      end
      StIrqJmp: begin
        w_squash    = 1'b1;
        w_irq_busy  = 1'b1;
        w_pc_load   = 1'b1;
        w_clr_i     = 1'b1;
        w_pc_target = w_vec_addr;
        w_state_nxt = 2'd0;
        w_fsm_nxt   = StRun;
      end
      default: begin
        w_state_nxt = 2'd0;
        w_fsm_nxt   = StRun;
      end
    endcase

    if (bus.hold) begin
      w_fsm_nxt   = r_fsm;
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_vec_nxt   = r_vec;
      w_irq_ack   = 1'b0;
      w_push_en   = 1'b0;
      w_pc_load   = 1'b0;
      w_clr_i     = 1'b0;
    end
    // irq_ack is decoded from live inputs, so keep it quiet while in reset.
    if (rst) w_irq_ack = 1'b0;
  end

  // Sequencer state registers; reset aborts any entry sequence immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= StRun;
      r_state <= 2'd0;
      r_pc    <= '0;
      r_vec   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_vec   <= w_vec_nxt;
    end
  end

  assign bus.state     = r_state;
  assign bus.squash    = w_squash;
  assign bus.irq_ack   = w_irq_ack;
  assign bus.irq_busy  = w_irq_busy;
  assign bus.push_en   = w_push_en;
  assign bus.push_data = w_push_data;
  assign bus.pc_load   = w_pc_load;
  assign bus.pc_target = w_pc_target;
  assign bus.clr_i     = w_clr_i;

endmodule

// File: tb/tb_growl_seq_ctrl.sv
// Self-checking bench for growl_seq_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_growl_seq_ctrl;
  localparam int unsigned VEC_W    = 5;
  localparam int unsigned PC_W     = 16;
  localparam int unsigned VEC_BASE = 0;

  logic clk = 1'b0;
  logic rst;

  growl_seq_ctrl_if #(.VEC_W(VEC_W), .PC_W(PC_W)) bus ();

  growl_seq_ctrl #(.VEC_W(VEC_W), .PC_W(PC_W), .VEC_BASE(VEC_BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the entry sequence is a queue of pending special cycles,
  // a skip is a count of words still to squash.
  typedef struct packed {
    logic            push;
    logic            load;
    logic [7:0]      data;
    logic [PC_W-1:0] tgt;
  } ent_t;

  ent_t m_q[$];
  int   m_state;
  int   m_sq_left;
  int   m_sq_done;
  bit   m_guard;

  int checks;
  int errors;

  logic [1:0]      o_state;
  logic            o_sq, o_ack, o_busy, o_push, o_load, o_clr;
  logic [7:0]      o_data;
  logic [PC_W-1:0] o_tgt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state   = 0;
    m_sq_left = 0;
    m_sq_done = 0;
    m_guard   = 0;
  endtask

  task automatic set_idle();
    bus.hold          = 1'b0;
    bus.c_next_state  = 2'd0;
    bus.c_skip        = 1'b0;
    bus.skip_cond     = 1'b0;
    bus.next_two_word = 1'b0;
    bus.irq_req       = 1'b0;
    bus.irq_vec       = '0;
    bus.sreg_i        = 1'b1;
    bus.reti_done     = 1'b0;
    bus.pc_cur        = '0;
  endtask

  // One clock: inputs already driven; check outputs, then advance the model.
  task automatic cycle();
    logic [1:0]      e_state;
    logic            e_sq, e_ack, e_busy, e_push, e_load;
    logic [7:0]      e_data;
    logic [PC_W-1:0] e_tgt;
    bit              bnd, irq_ok, skip_take;
    ent_t            e;
    #1;
    bnd       = (bus.c_next_state == 2'd0);
    skip_take = bus.c_skip && bus.skip_cond;
    irq_ok    = bus.irq_req && bus.sreg_i;
`ifdef GROWL_RETI_GUARD_EN
    irq_ok    = irq_ok && !m_guard && !bus.reti_done;
`endif
    e_state = 2'd0; e_sq = 0; e_ack = 0; e_busy = 0; e_push = 0; e_load = 0;
    e_data  = 8'h00; e_tgt = '0;
    if (rst) begin
      // all zero
    end else if (m_q.size() != 0) begin
      e_sq   = 1;
      e_busy = 1;
      e_push = m_q[0].push && !bus.hold;
      e_load = m_q[0].load && !bus.hold;
      e_data = m_q[0].data;
      e_tgt  = m_q[0].tgt;
    end else if (m_sq_left > 0) begin
      e_sq = 1;
    end else begin
      e_state = 2'(m_state);
      e_ack   = bnd && !skip_take && irq_ok && !bus.hold;
    end

    o_state = bus.state;   o_sq   = bus.squash;  o_ack  = bus.irq_ack;
    o_busy  = bus.irq_busy; o_push = bus.push_en; o_data = bus.push_data;
    o_load  = bus.pc_load;  o_clr  = bus.clr_i;   o_tgt  = bus.pc_target;

    check("state", o_state, e_state);
    check("squash", o_sq, e_sq);
    check("irq_ack", o_ack, e_ack);
    check("irq_busy", o_busy, e_busy);
    check("push_en", o_push, e_push);
    check("pc_load", o_load, e_load);
    check("clr_i", o_clr, e_load);
    if (e_push || rst) check("push_data", o_data, e_data);
    if (e_load || rst) check("pc_target", o_tgt, e_tgt);

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!bus.hold) begin
      if (m_q.size() != 0) begin
        void'(m_q.pop_front());
        m_state = 0;
      end else if (m_sq_left > 0) begin
        if (m_sq_done == 0 && bus.next_two_word) m_sq_left++;
        m_sq_left--;
        m_sq_done++;
        m_state = 0;
      end else begin
        m_state = int'(bus.c_next_state);
        if (bnd) begin
          m_guard = 0;
          if (skip_take) begin
            m_sq_left = 1;
            m_sq_done = 0;
          end else if (irq_ok) begin
            e = '{push: 1'b1, load: 1'b0, data: 8'(bus.pc_cur % 256), tgt: '0};
            m_q.push_back(e);
            e = '{push: 1'b1, load: 1'b0, data: 8'((bus.pc_cur / 256) % 256), tgt: '0};
            m_q.push_back(e);
            e = '{push: 1'b0, load: 1'b1, data: 8'h00,
                  tgt: PC_W'((VEC_BASE + 2 * int'(bus.irq_vec)) % (1 << PC_W))};
            m_q.push_back(e);
          end
        end
      end
      if (bus.reti_done) m_guard = 1;
    end
    #1;
  endtask

  initial begin
    int n;
    int n2;
    checks = 0;
    errors = 0;
    model_reset();
    set_idle();
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_state", o_state, 2'd0);
    check("rst_push_data", o_data, 8'h00);
    check("rst_pc_target", o_tgt, 16'h0000);
    rst = 1'b0;
    cycle();

    // Phase sequencing 1,2,0
    bus.c_next_state = 2'd1; cycle(); check("phase_a", o_state, 2'd0);
    bus.c_next_state = 2'd2; cycle(); check("phase_b", o_state, 2'd1);
    bus.c_next_state = 2'd0; cycle(); check("phase_c", o_state, 2'd2);
    cycle(); check("phase_d", o_state, 2'd0); check("phase_squash", o_sq, 1'b0);

    // Skip over two-word then one-word instruction; c_skip held during squash is ignored
    for (int w = 1; w >= 0; w--) begin
      n = 0;
      set_idle();
      bus.c_skip = 1'b1; bus.skip_cond = 1'b1; cycle();
      bus.next_two_word = (w == 1);
      for (int k = 0; k < 4; k++) begin
        cycle();
        n += int'(o_sq);
        bus.c_skip = 1'b0;
      end
      check(w == 1 ? "skip2_len" : "skip1_len", n, w + 1);
    end

    // Interrupt entry, vector 5, return PC 0x1234
    set_idle();
    bus.irq_req = 1'b1; bus.irq_vec = 5'd5; bus.pc_cur = 16'h1234;
    cycle(); check("irq_ack", o_ack, 1'b1);
    bus.irq_req = 1'b0; bus.irq_vec = 5'd31; bus.pc_cur = 16'hffff;
    cycle(); check("push_lo_en", o_push, 1'b1); check("push_lo", o_data, 8'h34);
    cycle(); check("push_hi_en", o_push, 1'b1); check("push_hi", o_data, 8'h12);
    cycle(); check("vec_load", o_load, 1'b1); check("vec_tgt", o_tgt, 16'h000a);
    check("vec_clr_i", o_clr, 1'b1);
    set_idle();
    cycle(); check("post_irq_busy", o_busy, 1'b0); check("post_irq_squash", o_sq, 1'b0);

    // Hold for 3 cycles in IRQ_LO
    bus.irq_req = 1'b1; bus.irq_vec = 5'd5; bus.pc_cur = 16'h1234;
    cycle();
    set_idle();
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("hold_push", o_push, 1'b0);
      check("hold_busy", o_busy, 1'b1);
    end
    bus.hold = 1'b0;
    n  = 0;
    n2 = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (o_push && o_data == 8'h34) n++;
      n2 += int'(o_load);
    end
    check("hold_lo_pushes", n, 1);
    check("hold_loads", n2, 1);

    // Reset during IRQ_HI
    bus.irq_req = 1'b1; bus.irq_vec = 5'd3; bus.pc_cur = 16'habcd;
    cycle();
    set_idle();
    cycle();
    rst = 1'b1;
    cycle(); check("rstmid_push", o_push, 1'b0); check("rstmid_state", o_state, 2'd0);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n += int'(o_load);
    end
    check("rstmid_no_load", n, 0);

    // RETI guard
    set_idle();
    bus.reti_done = 1'b1;
    cycle();
    bus.reti_done = 1'b0; bus.irq_req = 1'b1; bus.irq_vec = 5'd1; bus.pc_cur = 16'h0042;
    cycle();
`ifdef GROWL_RETI_GUARD_EN
    check("guard_first_boundary", o_ack, 1'b0);
    cycle();
    check("guard_second_boundary", o_ack, 1'b1);
`else
    check("noguard_first_boundary", o_ack, 1'b1);
`endif
    set_idle();
    repeat (4) cycle();

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      bus.hold          = ($urandom_range(0, 7) == 0);
      bus.c_next_state  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      bus.c_skip        = ($urandom_range(0, 3) == 0);
      bus.skip_cond     = 1'($urandom_range(0, 1));
      bus.next_two_word = 1'($urandom_range(0, 1));
      bus.irq_req       = ($urandom_range(0, 5) == 0);
      bus.irq_vec       = VEC_W'($urandom);
      bus.sreg_i        = ($urandom_range(0, 3) != 0);
      bus.reti_done     = ($urandom_range(0, 15) == 0);
      bus.pc_cur        = PC_W'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/growl_seq_ctrl.md
Name: growl_seq_ctrl

Overview:
- Multi-cycle sequencer for the growl AVR-class core.
- Owns the 2-bit instruction-phase register that the control decoder consumes as `state`. Updates it from the decoder's `c_next_state`.
- Squashes skipped instruction words (1- or 2-word) after skip-type instructions.
- Inserts the 3-cycle interrupt entry sequence (push PC low, push PC high, vector jump) at instruction boundaries.

Parameters:
- VEC_W, 5, width of interrupt vector number.
- PC_W, 16, program-counter width in words.
- VEC_BASE, 0, word address of vector 0; vector n is at VEC_BASE + 2*n.

Ports:
- clk  in  1  core clock, all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  memory wait; freezes all sequencer state while high.
- c_next_state  in  2  next phase from the control decoder; 0 means the current instruction completes this cycle.
- c_skip  in  1  the current instruction is a skip-type instruction.
- skip_cond  in  1  the skip condition is true (valid with c_skip).
- next_two_word  in  1  the prefetched next instruction is 2 words (LDS/STS/JMP/CALL).
- irq_req  in  1  level interrupt request.
- irq_vec  in  VEC_W  vector number of the highest-priority pending source.
- sreg_i  in  1  global interrupt enable (SREG.I).
- reti_done  in  1  single-cycle pulse when RETI completes.
- pc_cur  in  PC_W  address of the next instruction to execute (the return address).
- state  out  2  phase to the control decoder.
- squash  out  1  the current fetched word executes as a NOP.
- irq_ack  out  1  one-cycle pulse in the first cycle of entry.
- irq_busy  out  1  high during the entry sequence.
- push_en  out  1  push one byte to the stack.
- push_data  out  8  byte to push.
- pc_load  out  1  load PC with pc_target.
- pc_target  out  PC_W  vector address.
- clr_i  out  1  clear SREG.I (asserted together with pc_load).

Behaviour:
- Reset values:
  - FSM = RUN; state = 0.
  - All pulse outputs are 0; push_data = 0; pc_target = 0.
  - Latched return PC = 0.
- Reset mid-sequence aborts immediately; no partial push completes after rst deasserts.
- FSM states: RUN, SKIP1, SKIP2, IRQ_LO, IRQ_HI, IRQ_JMP.
- hold=1: FSM, state and latched PC are frozen. All pulse outputs (push_en, pc_load, irq_ack, clr_i) are forced to 0. squash and irq_busy retain their values.
- RUN, with boundary = (c_next_state == 0):
  - Not a boundary: state <= c_next_state.
  - Boundary with c_skip & skip_cond: state <= 0; go to SKIP1.
  - Otherwise, boundary with irq_req & sreg_i & irq_allowed: latch pc_cur; go to IRQ_LO; irq_ack=1 this cycle.
  - Otherwise: state <= 0; stay in RUN.
  - Skip has priority over interrupt. The interrupt is re-evaluated at the boundary after the skip completes.
- SKIP1: squash=1; state held at 0.
  - next_two_word sampled this cycle: 1 goes to SKIP2, 0 goes to RUN.
- SKIP2: squash=1; then go to RUN.
  - c_skip is ignored during squash cycles (a squashed skip instruction cannot chain).
- IRQ_LO:
  - irq_busy=1, squash=1, push_en=1.
  - push_data = latched PC[7:0].
- IRQ_HI:
  - irq_busy=1, squash=1, push_en=1.
  - push_data = latched PC[15:8]; bits above PC_W read 0.
- IRQ_JMP:
  - irq_busy=1, squash=1.
  - pc_load=1; clr_i=1.
  - pc_target = VEC_BASE + (irq_vec_latched << 1), truncated to PC_W.
  - Then go to RUN with state=0.
- irq_vec is latched at ack. A change on irq_vec or irq_req during entry has no effect.
- Entry latency: irq_ack on the boundary cycle; vector fetch starts 4 cycles after the boundary.
- irq_allowed: always 1 unless the optional feature is enabled.

Optional Feature:
- Macro GROWL_RETI_GUARD_EN.
- Defined: a guard flag sets on reti_done and clears at the next instruction boundary taken in RUN. While the flag is set, irq_allowed=0. This guarantees one main-program instruction executes between RETI and the next interrupt entry.
- Not defined: reti_done is ignored and irq_allowed=1. An interrupt can be taken at the boundary immediately following RETI.

Test Plan:
- rst pulsed mid-IRQ_HI -> push_en=0 and state=0 immediately; FSM=RUN after release; no pc_load occurs.
- c_next_state sequence 1,2,0 with no skip or irq -> state outputs 0,1,2,0; squash stays 0.
- Skip taken at boundary, next_two_word=1 -> squash=1 for exactly 2 cycles, then RUN; with next_two_word=0 -> exactly 1 cycle.
- irq_req=1, sreg_i=1, irq_vec=5, pc_cur=0x1234, VEC_BASE=0 at boundary:
  - irq_ack pulse.
  - Pushes 0x34 then 0x12.
  - pc_load with pc_target=0x000A and clr_i=1.
- hold=1 for 3 cycles during IRQ_LO -> push_en=0 while held; exactly one 0x34 push after release; total sequence is otherwise unchanged.
- GROWL_RETI_GUARD_EN: reti_done then irq_req held high -> the first boundary takes no irq; the second boundary acks. Without the macro, the first boundary acks.
